// File: rtl/reset_sequencer.sv
// Reset sequencer for the SCR1 top. It synchronises the board reset, stretches the core reset,
// re-issues it on a software request or a watchdog timeout, and records the reset cause and count.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned WDT_TIMEOUT = 5000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_rst_req,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  output logic             core_rst,
  output logic             rst_done,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] rst_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned WDT_W  = $clog2(WDT_TIMEOUT);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic {
    HOLD,
    RUN
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_sync;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [WDT_W-1:0]  wdt_q;
  logic              core_rst_q;
  logic              rst_done_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  count_q;
  logic              wdt_fire;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Timeout only when the counter sits on its last value and no kick rescues it.
  assign wdt_fire = wdt_en && !wdt_kick && (wdt_q == WDT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HOLD;
      hold_q     <= '0;
      wdt_q      <= '0;
      core_rst_q <= 1'b1;
      rst_done_q <= 1'b0;
      cause_q    <= CAUSE_POR;
      count_q    <= '0;
    end else begin
      rst_done_q <= 1'b0;
      case (state_q)
        HOLD: begin
          core_rst_q <= 1'b1;
          wdt_q      <= '0;
          if (rst_sync) begin
            if (hold_q == HOLD_LAST) begin
              state_q    <= RUN;
              hold_q     <= '0;
              core_rst_q <= 1'b0;
              rst_done_q <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end else begin
            hold_q <= '0;
          end
        end
        RUN: begin
          core_rst_q <= 1'b0;
          if (sw_rst_req || wdt_fire) begin
            // A software request wins the cause when both land on the same edge.
            state_q    <= HOLD;
            hold_q     <= '0;
            wdt_q      <= '0;
            core_rst_q <= 1'b1;
            cause_q    <= sw_rst_req ? CAUSE_SW : CAUSE_WDT;
            if (count_q != '1) count_q <= count_q + 1'b1;
          end else if (!wdt_en || wdt_kick) begin
            wdt_q <= '0;
          end else begin
            wdt_q <= wdt_q + 1'b1;
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign rst_done  = rst_done_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each issued reset pushes its expected cause, count and
// hold length; a monitor checks them on every rst_done pulse.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       core_rst;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  typedef struct packed {
    logic [1:0]  cause;
    logic [7:0]  count;
    logic [31:0] len;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned hi_len   = 0;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(100),
    .WDT_TIMEOUT(5000),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .core_rst  (core_rst),
    .rst_done  (rst_done),
    .rst_cause (rst_cause),
    .rst_count (rst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: measures each core_rst high period and scores it on rst_done.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      hi_len = 0;
    end else if (rst_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_reset actual_cause=%0d actual_count=%0d expected=none",
                 rst_cause, rst_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cause", 32'(rst_cause), 32'(e.cause));
        check("done_count", 32'(rst_count), 32'(e.count));
        check("hold_len", hi_len, e.len);
        check("done_core_rst", 32'(core_rst), 32'd0);
      end
      hi_len = 0;
    end else if (core_rst === 1'b1) begin
      hi_len++;
    end
  end

  task automatic wait_done(input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (rst_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rst_done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_rst_done expected=rst_done_within_%0d", name, budget);
    end
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    @(posedge clk); #1;
    sw_rst_req = 1'b0;
  endtask

  task automatic kick_at_count(input int unsigned wait_edges);
    repeat (wait_edges) @(posedge clk);
    #1 wdt_kick = 1'b1;
    @(posedge clk); #1;
    wdt_kick = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst        = 1'b0;
    sw_rst_req = 1'b0;
    wdt_en     = 1'b0;
    wdt_kick   = 1'b0;

    // Power-on reset
    repeat (10) @(posedge clk);
    #1;
    check("por_core_rst", 32'(core_rst), 32'd1);
    check("por_done", 32'(rst_done), 32'd0);
    check("por_cause", 32'(rst_cause), 32'd0);
    check("por_count", 32'(rst_count), 32'd0);
    exp_q.push_back('{cause: 2'd0, count: 8'd0, len: 32'd102});
    rst = 1'b1;
    wait_done(200, "por");

    // Software reset, with the watchdog armed during its hold
    @(posedge clk); #1;
    exp_q.push_back('{cause: 2'd1, count: 8'd1, len: 32'd100});
    sw_pulse();
    wdt_en = 1'b1;
    wait_done(200, "sw");

    // Unkicked watchdog: core_rst rises 5000 edges after RUN entry
    exp_q.push_back('{cause: 2'd2, count: 8'd2, len: 32'd100});
    n = 0;
    while (core_rst !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("wdt_latency", n, 32'd5000);
    wait_done(200, "wdt");

    // Regular kicks at counter 4998 for ~20000 cycles
    for (int k = 0; k < 4; k++) kick_at_count(4998);
    check("kick_core_rst", 32'(core_rst), 32'd0);
    check("kick_count", 32'(rst_count), 32'd2);

    // Kick exactly on the timeout cycle (counter 4999)
    kick_at_count(4999);
    repeat (3) @(posedge clk);
    #1;
    check("boundary_core_rst", 32'(core_rst), 32'd0);
    check("boundary_count", 32'(rst_count), 32'd2);

    // Software request coinciding with the timeout edge; counter is 3 after the kick above
    repeat (4996) @(posedge clk);
    #1;
    exp_q.push_back('{cause: 2'd1, count: 8'd3, len: 32'd100});
    sw_pulse();
    check("simul_core_rst", 32'(core_rst), 32'd1);
    wdt_en = 1'b0;
    wait_done(200, "simul");

    // Request during the hold must not extend it
    @(posedge clk); #1;
    exp_q.push_back('{cause: 2'd1, count: 8'd4, len: 32'd100});
    sw_pulse();
    repeat (49) @(posedge clk);
    #1;
    sw_pulse();
    wait_done(200, "sw_in_hold");
    check("sw_in_hold_count", 32'(rst_count), 32'd4);

    // Saturation
    for (int i = 1; i <= 260; i++) begin
      exp_q.push_back('{cause: 2'd1, count: ((4 + i) > 255) ? 8'd255 : 8'(4 + i), len: 32'd100});
      sw_pulse();
      wait_done(200, "sat");
    end
    check("sat_count", 32'(rst_count), 32'd255);

    // Asynchronous reset mid-RUN takes effect before the next edge
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_core_rst", 32'(core_rst), 32'd1);
    check("async_count", 32'(rst_count), 32'd0);
    check("async_cause", 32'(rst_cause), 32'd0);
    check("async_done", 32'(rst_done), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back('{cause: 2'd0, count: 8'd0, len: 32'd102});
    rst = 1'b1;
    wait_done(200, "repor");

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Hardware counterpart of the bench-side reset driver for the SCR1 top.
- Takes the raw board reset and produces the synchronised, stretched, active-high core reset that feeds top's rst input.
- Re-issues the core reset on a software request or a watchdog timeout.
- Reports the cause of the last reset and keeps a running count of warm resets.

Parameters:
- SYNC_STAGES, 2, number of flops in the reset-deassertion synchroniser (minimum 2).
- HOLD_CYCLES, 100, clock cycles that core_rst stays asserted after each reset entry (minimum 1).
- WDT_TIMEOUT, 5000, cycles without a kick before a watchdog reset fires (minimum 2).
- CNT_W, 8, width of the warm-reset counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low board reset.
- sw_rst_req  input  1  single-cycle software reset request.
- wdt_en  input  1  watchdog enable (level).
- wdt_kick  input  1  watchdog service strobe.
- core_rst  output  1  active-high reset to the core top.
- rst_done  output  1  one-cycle pulse on the cycle core_rst first reads 0 after a hold.
- rst_cause  output  2  cause of the last reset: 00 POR, 01 SW, 10 WDT, 11 unused.
- rst_count  output  CNT_W  number of SW plus WDT resets since POR; saturating.

Behaviour:
- Reset scheme: one clock; rst is asynchronous and active-low.
  - rst=0 immediately forces: core_rst=1, rst_done=0, rst_cause=00, rst_count=0, state=HOLD, hold counter=0, watchdog counter=0, all synchroniser flops=0.
- Synchroniser:
  - Asserts asynchronously; deasserts through SYNC_STAGES flops clocked by clk.
  - The internal rst_sync reads 1 after the SYNC_STAGES-th rising edge following rst rising.
  - While rst_sync=0, the FSM is frozen in HOLD with the hold counter at 0.
- FSM has two states, HOLD and RUN.
  - HOLD:
    - core_rst=1.
    - The hold counter increments on each edge while rst_sync=1.
    - When the counter equals HOLD_CYCLES-1, the next edge moves to RUN, clears the counter, and makes core_rst=0 and rst_done=1 for that one cycle.
    - POR latency: core_rst falls exactly SYNC_STAGES+HOLD_CYCLES rising edges after rst rises.
    - Warm-reset latency: core_rst stays high for exactly HOLD_CYCLES cycles.
  - RUN:
    - core_rst=0.
    - sw_rst_req=1 at an edge: next state HOLD, core_rst=1 from that edge, rst_cause=01, rst_count increments.
    - Watchdog timeout at an edge: next state HOLD, rst_cause=10, rst_count increments.
- Watchdog counter (active only in RUN):
  - wdt_en=0: counter held at 0 and no timeout possible.
  - wdt_en=1: counter increments each cycle.
  - wdt_kick=1 clears the counter to 0; the kick has priority over the increment.
  - Timeout occurs when the counter equals WDT_TIMEOUT-1 and wdt_kick=0. A kick in that same cycle prevents the timeout.
  - The counter clears on every entry to HOLD and stays 0 throughout HOLD.
- Simultaneous events:
  - sw_rst_req together with a watchdog timeout: one reset entry, rst_cause=01 (SW wins), rst_count increments by 1.
  - sw_rst_req or kick during HOLD: ignored. A hold is never extended or restarted.
- rst_count saturates at 2^CNT_W-1. It is cleared only by rst.
- rst_cause holds its value until the next reset entry.
- rst asserted mid-HOLD or mid-RUN: immediate return to the reset values above; rst_cause becomes 00.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- POR: hold rst=0 for 10 cycles, then release → core_rst=1 for exactly 102 edges, then 0 with rst_done=1 for one cycle; rst_cause=00; rst_count=0.
- Software reset: in RUN, pulse sw_rst_req for 1 cycle → core_rst=1 for exactly 100 cycles then 0; rst_cause=01; rst_count=1.
- Watchdog:
  - wdt_en=1 with no kicks → core_rst rises 5000 cycles after entering RUN; rst_cause=10; rst_count increments.
  - Kicking every 4999 cycles for 20000 cycles → no reset.
  - Kick in the boundary cycle (counter=4999) → no reset.
- Simultaneous: sw_rst_req in the same cycle as the watchdog timeout → a single reset entry, rst_cause=01, rst_count +1.
  - sw_rst_req at hold cycle 50 → the hold still ends at cycle 100.
- Saturation and mid-operation reset:
  - 260 software resets → rst_count=255.
  - Drive rst=0 mid-RUN → core_rst=1 immediately (before the next edge); rst_count=0; rst_cause=00.
